fi_mem_responder: RTL
=====================

// Module: fi_mem_responder
// PURPOSE
//  Formal/sim memory-side responder for one core memory port (imem or dmem).
//  - Turns unconstrained solver inputs (stim_*) into a protocol-legal
//    req/gnt + recv/ack response stream.
//  - Feeds the fairness checker; the bounds below are enforced by construction.
//  - Instantiated once per port in the RVFI harness.
// PARAMETERS
//  MAX_GNT_STALL  3  max consecutive cycles a request may wait for gnt (FIFO not full)
//  MAX_RSP_STALL  3  max consecutive cycles a queued response may wait for recv
//  DEPTH          4  outstanding-transaction FIFO depth; power of 2, >=2
//  ERR_EN         0  1: stim_error may propagate to mem_error; 0: mem_error tied 0
// PORTS
//  clock          in   1   clock
//  reset          in   1   synchronous, active-high reset
//  mem_req        in   1   core request valid
//  mem_wen        in   1   request is a write
//  mem_addr       in   32  request address
//  mem_gnt        out  1   request accepted this cycle
//  mem_recv       out  1   response valid
//  mem_ack        in   1   core accepts response
//  mem_rdata      out  32  read data (0 for writes)
//  mem_error      out  1   bus error for this response
//  stim_gnt       in   1   free input: solver wishes to grant
//  stim_rsp       in   1   free input: solver wishes to respond
//  stim_rdata     in   32  free input: response data
//  stim_error     in   1   free input: response error
//  outstanding    out  3   granted-but-unacked count, 0..DEPTH; width $clog2(DEPTH)+1
// BEHAVIOUR
//  Reset values: mem_recv=0, mem_rdata=0, mem_error=0, outstanding=0.
//  - Counters and FIFO are cleared.
//  - mem_gnt is forced 0 while reset is high.
//  Grant (combinational):
//    mem_gnt = mem_req && !full && (stim_gnt || gnt_stall==MAX_GNT_STALL).
//  gnt_stall (registered, saturating at MAX_GNT_STALL):
//    - increments when mem_req && !mem_gnt && !full;
//    - holds while full;
//    - clears on mem_gnt or when !mem_req.
//  A grant pushes {wen,addr} into the FIFO in the same cycle.
//  Full blocks grant even if a pop occurs in the same cycle; there is no bypass.
//  Response start:
//    - Condition: !mem_recv && !empty && (stim_rsp || rsp_stall==MAX_RSP_STALL).
//    - mem_recv rises at the next edge, so minimum latency is 1 cycle
//      from the gnt cycle to mem_recv.
//    - Data/error are captured on the same edge:
//      mem_rdata = wen ? 0 : stim_rdata; mem_error = ERR_EN ? stim_error : 0.
//  rsp_stall:
//    - increments when !empty && !mem_recv and the response does not start;
//    - saturates at MAX_RSP_STALL; clears when a response starts.
//  Hold rule: while mem_recv && !mem_ack, mem_recv/mem_rdata/mem_error are
//  stable and stim_* are ignored.
//  Pop on mem_recv && mem_ack:
//    - mem_recv falls at the next edge unless a new response starts in the
//      same cycle (back-to-back allowed when FIFO depth after pop > 0).
//    - mem_rdata/mem_error hold their last value when mem_recv=0.
//  outstanding += (gnt) - (recv&&ack) each cycle; simultaneous push and pop
//  leaves it unchanged.
//  Pointers wrap modulo DEPTH. full = (count==DEPTH), empty = (count==0).
//  Reset mid-transaction: all queued transactions are dropped and no response
//  is issued for them.
//  mem_ack while !mem_recv is ignored.
// STRUCTURE
//  fi_pkg: typedef fi_mem_txn_t {logic wen; logic [31:0] addr;}; constant
//  FI_XLEN=32.
//  Sub-module fi_txn_fifo:
//    - synchronous FIFO: push/pop/full/empty/count, DEPTH-parameterised;
//    - registered head output.
//  Top level holds the stall counters, response register and grant logic.
// TESTING
//  1 stim_gnt=0, mem_req held high -> mem_gnt=1 on 4th request cycle
//    (3 stall cycles); outstanding becomes 1.
//  2 stim_rsp=0 after one read grant -> mem_recv=1 exactly 4 cycles after
//    grant edge; mem_rdata=stim_rdata sampled at that edge.
//  3 Four grants with mem_ack=0 -> outstanding=4, mem_gnt=0 on 5th request;
//    one ack -> gnt possible next cycle, outstanding=4 after new push.
//  4 mem_recv=1, mem_ack=0 for 5 cycles, stim_rdata toggling ->
//    mem_rdata constant; write txn gives mem_rdata=0.
//  5 ERR_EN=0, stim_error=1 -> mem_error=0; ERR_EN=1 -> mem_error=1 with recv.
//  6 reset asserted with 3 outstanding -> next cycle outstanding=0, mem_recv=0,
//    no further responses.

Source files
------------

// File: rtl/fi_pkg.sv
// ---------------------------------------------------------------------------
// fi_pkg
//   Shared types for the memory-side fault-injection responder.
//   FI_XLEN      : data/address width of a core memory port
//   fi_mem_txn_t : one granted transaction as held in the outstanding FIFO
//   FI_TXN_W     : flat width of fi_mem_txn_t, used on sub-module ports
// ---------------------------------------------------------------------------
package fi_pkg;

    localparam int FI_XLEN = 32;

    typedef struct packed {
        logic               wen;
        logic [FI_XLEN-1:0] addr;
    } fi_mem_txn_t;

    localparam int FI_TXN_W = $bits(fi_mem_txn_t);

endpackage

// File: rtl/fi_txn_fifo.sv
// ---------------------------------------------------------------------------
// fi_txn_fifo
//   Synchronous FIFO of granted-but-unacked transactions.
//   The head entry is held in its own register so the response logic sees
//   a stable value; the entry behind the head is also exposed so a
//   back-to-back response can pick up its write flag in the pop cycle.
// Ports
//   clock, reset     : clock, synchronous active-high reset
//   push, push_data  : enqueue (ignored when full)
//   pop              : dequeue the head (ignored when empty)
//   head             : oldest entry (valid when !empty)
//   second           : entry behind the head (valid when has_second)
//   has_second       : at least two entries are queued
//   count            : number of queued entries, 0..DEPTH
//   full, empty      : count==DEPTH, count==0
// ---------------------------------------------------------------------------
module fi_txn_fifo
    import fi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [FI_TXN_W-1:0]     push_data,
    input  logic                    pop,
    output logic [FI_TXN_W-1:0]     head,
    output logic [FI_TXN_W-1:0]     second,
    output logic                    has_second,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    ONE_CNT  = (PTR_W + 1)'(1);

    logic [FI_TXN_W-1:0] mem [DEPTH];
    logic [FI_TXN_W-1:0] head_q;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    rd_ptr_nxt;
    logic [PTR_W:0]      count_q;
    logic                do_push;
    logic                do_pop;

    assign full       = (count_q == FULL_CNT);
    assign empty      = (count_q == '0);
    assign has_second = (count_q > ONE_CNT);
    assign do_push    = push && !full;
    assign do_pop     = pop && !empty;
    // DEPTH is a power of two, so pointer arithmetic wraps for free.
    assign rd_ptr_nxt = rd_ptr + 1'b1;

    // NOTE: storage is deliberately not reset; count/pointers define which
    // entries are live, and dropping the reset keeps the array as plain RAM.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // Head register: after a pop the next entry comes from storage if one is
    // queued, otherwise from a simultaneous push; a push into an empty FIFO
    // lands directly in the head.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q <= '0;
        end else if (do_pop && has_second) begin
            head_q <= mem[rd_ptr_nxt];
        end else if (do_push && (empty || do_pop)) begin
            head_q <= push_data;
        end
    end

    assign head   = head_q;
    assign second = mem[rd_ptr_nxt];
    assign count  = count_q;

endmodule

// File: rtl/fi_mem_responder.sv
// ---------------------------------------------------------------------------
// fi_mem_responder
//   Memory-side responder for one core memory port. Free solver inputs
//   (stim_*) are shaped into a legal req/gnt + recv/ack stream; stall
//   counters force a grant / response once a wait reaches its bound.
// Ports
//   clock, reset        : clock, synchronous active-high reset
//   mem_req/wen/addr    : core request
//   mem_gnt             : request accepted this cycle (combinational)
//   mem_recv            : response valid
//   mem_ack             : core accepts response
//   mem_rdata           : read data (0 for writes)
//   mem_error           : bus error for this response (0 unless ERR_EN)
//   stim_gnt/rsp        : solver wishes to grant / respond
//   stim_rdata/error    : solver-chosen response payload
//   outstanding         : granted-but-unacked count, 0..DEPTH
// ---------------------------------------------------------------------------
module fi_mem_responder
    import fi_pkg::*;
#(
    parameter int MAX_GNT_STALL = 3,
    parameter int MAX_RSP_STALL = 3,
    parameter int DEPTH         = 4,
    parameter bit ERR_EN        = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    mem_req,
    input  logic                    mem_wen,
    input  logic [FI_XLEN-1:0]      mem_addr,
    output logic                    mem_gnt,
    output logic                    mem_recv,
    input  logic                    mem_ack,
    output logic [FI_XLEN-1:0]      mem_rdata,
    output logic                    mem_error,
    input  logic                    stim_gnt,
    input  logic                    stim_rsp,
    input  logic [FI_XLEN-1:0]      stim_rdata,
    input  logic                    stim_error,
    output logic [$clog2(DEPTH):0]  outstanding
);

    localparam int              GS_W    = $clog2(MAX_GNT_STALL + 1);
    localparam int              RS_W    = $clog2(MAX_RSP_STALL + 1);
    localparam logic [GS_W-1:0] GNT_SAT = GS_W'(MAX_GNT_STALL);
    localparam logic [RS_W-1:0] RSP_SAT = RS_W'(MAX_RSP_STALL);

    fi_mem_txn_t     push_txn;
    fi_mem_txn_t     head;
    fi_mem_txn_t     second;
    logic            has_second;
    logic            full;
    logic            empty;
    logic [GS_W-1:0] gnt_stall;
    logic [RS_W-1:0] rsp_stall;
    logic            rsp_pop;
    logic            rsp_start;
    logic            rsp_wen;
    logic            unused_addr;

    assign push_txn = '{wen: mem_wen, addr: mem_addr};

    // Full blocks the grant even when a pop happens this cycle (no bypass).
    assign mem_gnt = !reset && mem_req && !full
                     && (stim_gnt || (gnt_stall == GNT_SAT));

    assign rsp_pop = mem_recv && mem_ack;

    fi_txn_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (mem_gnt),
        .push_data  (push_txn),
        .pop        (rsp_pop),
        .head       (head),
        .second     (second),
        .has_second (has_second),
        .count      (outstanding),
        .full       (full),
        .empty      (empty)
    );

    // The address travels with the transaction for traceability only; the
    // response payload never depends on it.
    assign unused_addr = ^{head.addr, second.addr};

    // A response may start from idle when something is queued, or
    // back-to-back in the ack cycle when another entry sits behind the one
    // being retired (that entry's write flag comes from 'second').
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        rsp_start = 1'b0;
        rsp_wen   = head.wen;
        if (mem_recv) begin
            rsp_wen   = second.wen;
            rsp_start = mem_ack && has_second;
        end else begin
            rsp_start = !empty;
        end
        rsp_start = rsp_start && (stim_rsp || (rsp_stall == RSP_SAT));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gnt_stall <= '0;
        end else if (!mem_req || mem_gnt) begin
            gnt_stall <= '0;
        end else if (!full && (gnt_stall != GNT_SAT)) begin
            gnt_stall <= gnt_stall + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rsp_stall <= '0;
        end else if (rsp_start) begin
            rsp_stall <= '0;
        end else if (!empty && !mem_recv && (rsp_stall != RSP_SAT)) begin
            rsp_stall <= rsp_stall + 1'b1;
        end
    end

    // Payload is captured only when a response starts, so it holds through
    // an un-acked response and after mem_recv falls.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_recv  <= 1'b0;
            mem_rdata <= '0;
            mem_error <= 1'b0;
        end else if (rsp_start) begin
            mem_recv  <= 1'b1;
            mem_rdata <= rsp_wen ? '0 : stim_rdata;
            mem_error <= ERR_EN && stim_error;
        end else if (rsp_pop) begin
            mem_recv  <= 1'b0;
        end
    end

endmodule
